// File: rtl/lcd_responder_if.sv
// rtl/lcd_responder_if.sv - 8-bit e/rs/rw/data LCD bus between controller and panel
interface lcd_responder_if;
    logic       e;
    logic       rs;
    logic       rw;
    logic [7:0] lcd_data_in;
    logic [7:0] lcd_data_out;
    logic       data_oe;

    modport master (
        output e, rs, rw, lcd_data_in,
        input  lcd_data_out, data_oe
    );

    modport slave (
        input  e, rs, rw, lcd_data_in,
        output lcd_data_out, data_oe
    );
endinterface

// File: rtl/lcd_responder.sv
// rtl/lcd_responder.sv - HD44780-style panel-side responder with busy timing and DDRAM
module lcd_responder #(
    parameter int CLK_FREQ     = 180,
    parameter int CBITS        = 17,
    parameter int DDRAM_DEPTH  = 80,
    parameter int POR_CYCLES   = 400 * CLK_FREQ,
    parameter int CMD_CYCLES   = 37 * CLK_FREQ,
    parameter int CLEAR_CYCLES = 152 * CLK_FREQ
) (
    input  logic           clk,
    input  logic           rst_n,
    lcd_responder_if.slave bus,
    output logic           busy_flag,
    output logic [6:0]     ddram_addr,
    output logic           display_on,
    output logic           cursor_on,
    output logic           blink_on,
    output logic           inc_dec,
    output logic           shift_en,
    output logic           two_line,
    output logic           font_5x10,
    output logic           dl_8bit,
    output logic [6:0]     disp_shift,
    input  logic [6:0]     disp_rd_addr,
    output logic [7:0]     disp_rd_data,
    output logic           cmd_dropped
);

    localparam logic [6:0]       LAST_ADDR  = 7'(DDRAM_DEPTH - 1);
    localparam logic [7:0]       DEPTH_8    = 8'(DDRAM_DEPTH);
    localparam logic [CBITS-1:0] POR_LAST   = CBITS'(POR_CYCLES - 1);
    localparam logic [CBITS-1:0] CMD_LAST   = CBITS'(CMD_CYCLES - 1);
    localparam logic [CBITS-1:0] CLEAR_LAST = CBITS'(CLEAR_CYCLES - 1);

    typedef enum logic [1:0] {S_POR, S_IDLE, S_ACTIVE, S_BUSY} state_t;

    function automatic logic [6:0] step(input logic [6:0] v, input logic up);
        if (up)
            return (v == LAST_ADDR) ? 7'd0 : v + 7'd1;
        return (v == 7'd0) ? LAST_ADDR : v - 7'd1;
    endfunction

    state_t           state;
    logic             e_q;
    logic             cap_rs;
    logic             cap_rw;
    logic [7:0]       cap_data;
    logic [CBITS-1:0] cnt;
    logic [CBITS-1:0] cnt_last;
    logic             oe;
    logic [7:0]       ddram [DDRAM_DEPTH];

    logic rise;
    logic fall;
    logic exec;
    logic timed;
    logic long_op;

    assign rise = bus.e && !e_q;
    assign fall = !bus.e && e_q;
    // Writes landing in POR/BUSY are dropped; reads still execute while busy.
    assign exec = fall && (state != S_POR) && ((state != S_BUSY) || cap_rw);

    always_comb begin
        timed   = 1'b1;
        long_op = 1'b0;
        if (cap_rw) begin
            timed = cap_rs;
        end else if (!cap_rs) begin
            timed   = (cap_data != 8'h00);
            long_op = (cap_data[7:2] == 6'd0) && (cap_data[1:0] != 2'd0);
        end
    end

    assign bus.data_oe      = oe;
    assign bus.lcd_data_out = !oe    ? 8'h00 :
                              cap_rs ? ddram[ddram_addr] : {busy_flag, ddram_addr};
    assign disp_rd_data     = ({1'b0, disp_rd_addr} < DEPTH_8) ? ddram[disp_rd_addr] : 8'h20;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_POR;
            e_q         <= 1'b0;
            cap_rs      <= 1'b0;
            cap_rw      <= 1'b0;
            cap_data    <= 8'h00;
            cnt         <= '0;
            cnt_last    <= '0;
            oe          <= 1'b0;
            busy_flag   <= 1'b0;
            ddram_addr  <= 7'd0;
            disp_shift  <= 7'd0;
            display_on  <= 1'b0;
            cursor_on   <= 1'b0;
            blink_on    <= 1'b0;
            inc_dec     <= 1'b1;
            shift_en    <= 1'b0;
            two_line    <= 1'b0;
            font_5x10   <= 1'b0;
            dl_8bit     <= 1'b1;
            cmd_dropped <= 1'b0;
            for (int i = 0; i < DDRAM_DEPTH; i++)
                ddram[i] <= 8'h20;
        end else begin
            e_q         <= bus.e;
            cmd_dropped <= fall && !cap_rw && ((state == S_POR) || (state == S_BUSY));

            if (rise) begin
                cap_rs   <= bus.rs;
                cap_rw   <= bus.rw;
                cap_data <= bus.lcd_data_in;
                oe       <= bus.rw && (state != S_POR);
            end else if (fall) begin
                oe <= 1'b0;
            end

            case (state)
                S_POR: begin
                    // First clock after release loads the counter, so BF spans exactly POR_CYCLES.
                    if (!busy_flag) begin
                        busy_flag <= 1'b1;
                        cnt       <= '0;
                    end else if (cnt == POR_LAST) begin
                        state     <= S_IDLE;
                        busy_flag <= 1'b0;
                    end else begin
                        cnt <= cnt + CBITS'(1);
                    end
                end
                S_IDLE: begin
                    if (rise)
                        state <= S_ACTIVE;
                end
                S_BUSY: begin
                    if (cnt == cnt_last) begin
                        state     <= S_IDLE;
                        busy_flag <= 1'b0;
                    end else begin
                        cnt <= cnt + CBITS'(1);
                    end
                end
                default: ;
            endcase

            if (exec) begin
                if (!timed) begin
                    if (state != S_BUSY)
                        state <= S_IDLE;
                end else begin
                    state     <= S_BUSY;
                    busy_flag <= 1'b1;
                    cnt       <= '0;
                    cnt_last  <= long_op ? CLEAR_LAST : CMD_LAST;
                end

                if (cap_rs) begin
                    if (!cap_rw)
                        ddram[ddram_addr] <= cap_data;
                    ddram_addr <= step(ddram_addr, inc_dec);
                    if (!cap_rw && shift_en)
                        disp_shift <= step(disp_shift, inc_dec);
                end else if (!cap_rw) begin
                    casez (cap_data)
                        8'b1???_????: begin
                            ddram_addr <= ({1'b0, cap_data[6:0]} < DEPTH_8) ? cap_data[6:0] : 7'd0;
                        end
                        8'b01??_????: ;
                        8'b001?_????: begin
                            dl_8bit   <= cap_data[4];
                            two_line  <= cap_data[3];
                            font_5x10 <= cap_data[2];
                        end
                        8'b0001_????: begin
                            if (cap_data[3])
                                disp_shift <= step(disp_shift, cap_data[2]);
                            else
                                ddram_addr <= step(ddram_addr, cap_data[2]);
                        end
                        8'b0000_1???: begin
                            display_on <= cap_data[2];
                            cursor_on  <= cap_data[1];
                            blink_on   <= cap_data[0];
                        end
                        8'b0000_01??: begin
                            inc_dec  <= cap_data[1];
                            shift_en <= cap_data[0];
                        end
                        8'b0000_001?: begin
                            ddram_addr <= 7'd0;
                            disp_shift <= 7'd0;
                        end
                        8'b0000_0001: begin
                            for (int i = 0; i < DDRAM_DEPTH; i++)
                                ddram[i] <= 8'h20;
                            ddram_addr <= 7'd0;
                            disp_shift <= 7'd0;
                            inc_dec    <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_responder.sv
// tb/tb_lcd_responder.sv - self-checking bench for lcd_responder against a behavioural panel model
module tb_lcd_responder;

    localparam int F     = 8;
    localparam int DEPTH = 80;
    localparam int POR   = 400 * F;
    localparam int CMD   = 37 * F;
    localparam int CLR   = 152 * F;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lcd_responder_if bus();

    logic       busy_flag;
    logic [6:0] ddram_addr;
    logic       display_on, cursor_on, blink_on, inc_dec, shift_en, two_line, font_5x10, dl_8bit;
    logic [6:0] disp_shift;
    logic [6:0] disp_rd_addr;
    logic [7:0] disp_rd_data;
    logic       cmd_dropped;
    logic [7:0] flags;

    assign flags = {display_on, cursor_on, blink_on, inc_dec, shift_en, two_line, font_5x10, dl_8bit};

    lcd_responder #(.CLK_FREQ(F)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .busy_flag    (busy_flag),
        .ddram_addr   (ddram_addr),
        .display_on   (display_on),
        .cursor_on    (cursor_on),
        .blink_on     (blink_on),
        .inc_dec      (inc_dec),
        .shift_en     (shift_en),
        .two_line     (two_line),
        .font_5x10    (font_5x10),
        .dl_8bit      (dl_8bit),
        .disp_shift   (disp_shift),
        .disp_rd_addr (disp_rd_addr),
        .disp_rd_data (disp_rd_data),
        .cmd_dropped  (cmd_dropped)
    );

    int checks = 0;
    int errors = 0;
    int drops  = 0;

    always @(negedge clk) if (cmd_dropped === 1'b1) drops++;

    // Behavioural panel model
    logic [7:0] m_ram [DEPTH];
    int         m_ac, m_shift;
    bit         m_d, m_c, m_b, m_id, m_s, m_n, m_f, m_dl;

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) m_ram[i] = 8'h20;
        m_ac = 0; m_shift = 0;
        {m_d, m_c, m_b, m_s, m_n, m_f} = '0;
        m_id = 1; m_dl = 1;
    endfunction

    function automatic logic [7:0] model_flags();
        return {m_d, m_c, m_b, m_id, m_s, m_n, m_f, m_dl};
    endfunction

    function automatic int model_write(input bit rs, input logic [7:0] d);
        int dir;
        dir = m_id ? 1 : DEPTH - 1;
        if (rs) begin
            m_ram[m_ac] = d;
            m_ac = (m_ac + dir) % DEPTH;
            if (m_s) m_shift = (m_shift + dir) % DEPTH;
            return CMD;
        end
        if (d == 0) return 0;
        if (d >= 128) begin m_ac = (int'(d) - 128 < DEPTH) ? int'(d) - 128 : 0; return CMD; end
        if (d >= 64) return CMD;
        if (d >= 32) begin m_dl = d[4]; m_n = d[3]; m_f = d[2]; return CMD; end
        if (d >= 16) begin
            dir = d[2] ? 1 : DEPTH - 1;
            if (d[3]) m_shift = (m_shift + dir) % DEPTH;
            else      m_ac    = (m_ac + dir) % DEPTH;
            return CMD;
        end
        if (d >= 8) begin m_d = d[2]; m_c = d[1]; m_b = d[0]; return CMD; end
        if (d >= 4) begin m_id = d[1]; m_s = d[0]; return CMD; end
        m_ac = 0; m_shift = 0;
        if (d == 1) begin
            for (int i = 0; i < DEPTH; i++) m_ram[i] = 8'h20;
            m_id = 1;
        end
        return CLR;
    endfunction

    // Bus driver: leaves e low at a falling clock edge, execution happens on the next rising edge.
    task automatic bus_access(input bit rs, input bit rw, input logic [7:0] d, input int width,
                              output logic [7:0] rd, output logic oe);
        @(negedge clk);
        bus.rs = rs; bus.rw = rw; bus.lcd_data_in = d; bus.e = 1'b1;
        repeat (width) @(negedge clk);
        rd = bus.lcd_data_out;
        oe = bus.data_oe;
        bus.e = 1'b0;
    endtask

    task automatic lcd_write(input bit rs, input logic [7:0] d);
        logic [7:0] rd;
        logic       oe;
        bus_access(rs, 1'b0, d, 10, rd, oe);
    endtask

    task automatic measure_busy(output int n);
        n = 0;
        @(negedge clk);
        while (busy_flag === 1'b1 && n < 10000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (busy_flag !== 1'b0 && t < 5000) begin
            t++;
            @(negedge clk);
        end
        checks++;
        if (busy_flag !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: busy_flag=%b after %0d cycles, required 0", busy_flag, t);
        end
    endtask

    task automatic ram_not_blank(output int bad);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            disp_rd_addr = 7'(i);
            #1;
            if (disp_rd_data !== 8'h20) bad++;
        end
    endtask

    task automatic read_ram(input int a, output logic [7:0] v);
        disp_rd_addr = 7'(a);
        #1;
        v = disp_rd_data;
    endtask

    task automatic test_reset();
        int         n, bad;
        logic [7:0] v;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy_flag !== 1'b0) begin errors++; $display("FAIL reset_bf: got %b want 0", busy_flag); end
        checks++; if (flags !== 8'h11) begin errors++; $display("FAIL reset_flags: got %h want 11", flags); end
        checks++; if (ddram_addr !== 7'd0 || disp_shift !== 7'd0) begin errors++; $display("FAIL reset_addr: ac=%0d shift=%0d want 0/0", ddram_addr, disp_shift); end
        checks++; if (bus.data_oe !== 1'b0 || bus.lcd_data_out !== 8'h00 || cmd_dropped !== 1'b0) begin errors++; $display("FAIL reset_bus: oe=%b out=%h drop=%b want 0/00/0", bus.data_oe, bus.lcd_data_out, cmd_dropped); end
        ram_not_blank(bad);
        checks++; if (bad != 0) begin errors++; $display("FAIL reset_ram: %0d non-blank bytes want 0", bad); end
        read_ram(100, v);
        checks++; if (v !== 8'h20) begin errors++; $display("FAIL oor_scan: got %h want 20", v); end
        rst_n = 1'b1;
        measure_busy(n);
        checks++; if (n != POR) begin errors++; $display("FAIL por_len: got %0d want %0d", n, POR); end
    endtask

    task automatic test_init();
        int n;
        lcd_write(1'b0, 8'h38);
        measure_busy(n);
        checks++; if (n != CMD) begin errors++; $display("FAIL cmd_len: got %0d want %0d", n, CMD); end
        repeat (5) @(negedge clk);
        lcd_write(1'b0, 8'h0E); wait_idle(); repeat (5) @(negedge clk);
        lcd_write(1'b0, 8'h06); wait_idle();
        checks++; if (flags !== 8'hD5) begin errors++; $display("FAIL init_flags: got %h want d5", flags); end
    endtask

    task automatic test_data_write();
        logic [7:0] rd, v0, v1;
        logic       oe;
        lcd_write(1'b0, 8'h80); wait_idle();
        lcd_write(1'b1, 8'h41); wait_idle();
        lcd_write(1'b1, 8'h42);
        bus_access(1'b0, 1'b1, 8'h00, 6, rd, oe);
        checks++; if (rd !== 8'h82 || oe !== 1'b1) begin errors++; $display("FAIL busy_read: got %h oe=%b want 82 oe=1", rd, oe); end
        wait_idle();
        read_ram(0, v0); read_ram(1, v1);
        checks++; if (v0 !== 8'h41 || v1 !== 8'h42) begin errors++; $display("FAIL data_write: got %h %h want 41 42", v0, v1); end
        checks++; if (ddram_addr !== 7'd2) begin errors++; $display("FAIL data_ac: got %0d want 2", ddram_addr); end
    endtask

    task automatic test_clear();
        int n, d0, bad;
        d0 = drops;
        lcd_write(1'b0, 8'h01);
        fork
            measure_busy(n);
            begin
                repeat (50) @(negedge clk);
                lcd_write(1'b1, 8'h55);
            end
        join
        checks++; if (n != CLR) begin errors++; $display("FAIL clear_len: got %0d want %0d", n, CLR); end
        checks++; if (drops - d0 != 1) begin errors++; $display("FAIL dropped: got %0d pulses want 1", drops - d0); end
        checks++; if (ddram_addr !== 7'd0 || disp_shift !== 7'd0) begin errors++; $display("FAIL clear_ac: ac=%0d shift=%0d want 0/0", ddram_addr, disp_shift); end
        ram_not_blank(bad);
        checks++; if (bad != 0) begin errors++; $display("FAIL clear_ram: %0d non-blank bytes want 0", bad); end
    endtask

    task automatic test_wrap();
        logic [7:0] v;
        lcd_write(1'b0, 8'hCF); wait_idle();
        checks++; if (ddram_addr !== 7'd79) begin errors++; $display("FAIL set_ac: got %0d want 79", ddram_addr); end
        lcd_write(1'b1, 8'h5A); wait_idle();
        read_ram(79, v);
        checks++; if (v !== 8'h5A || ddram_addr !== 7'd0) begin errors++; $display("FAIL wrap_up: ram=%h ac=%0d want 5a/0", v, ddram_addr); end
        lcd_write(1'b0, 8'h10); wait_idle();
        checks++; if (ddram_addr !== 7'd79) begin errors++; $display("FAIL wrap_down: got %0d want 79", ddram_addr); end
        lcd_write(1'b0, 8'hD5); wait_idle();
        checks++; if (ddram_addr !== 7'd0) begin errors++; $display("FAIL oor_ac: got %0d want 0", ddram_addr); end
    endtask

    task automatic test_reset_mid_busy();
        int         n;
        logic [7:0] v;
        lcd_write(1'b0, 8'h0C);
        repeat (20) @(negedge clk);
        checks++; if (busy_flag !== 1'b1 || display_on !== 1'b1) begin errors++; $display("FAIL pre_reset: bf=%b d=%b want 1/1", busy_flag, display_on); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy_flag !== 1'b0 || display_on !== 1'b0) begin errors++; $display("FAIL async_reset: bf=%b d=%b want 0/0", busy_flag, display_on); end
        read_ram(79, v);
        checks++; if (v !== 8'h20) begin errors++; $display("FAIL reset_ram79: got %h want 20", v); end
        @(negedge clk);
        rst_n = 1'b1;
        measure_busy(n);
        checks++; if (n != POR) begin errors++; $display("FAIL por_restart: got %0d want %0d", n, POR); end
    endtask

    task automatic test_random();
        int         n, exp_len, a, op, w;
        logic [7:0] d, rd, exp_rd, v;
        logic       oe;
        model_reset();
        for (int k = 0; k < 60; k++) begin
            op = $urandom_range(0, 3);
            w  = $urandom_range(2, 8);
            if (op == 0) begin
                case ($urandom_range(0, 7))
                    0: d = 8'h04 | 8'($urandom_range(0, 3));
                    1: d = 8'h10 | 8'($urandom_range(0, 3) << 2);
                    2: d = 8'h80 | 8'($urandom_range(0, 127));
                    3: d = 8'h08 | 8'($urandom_range(0, 7));
                    4: d = 8'h20 | 8'($urandom_range(0, 7) << 2);
                    5: d = 8'h40 | 8'($urandom_range(0, 63));
                    6: d = 8'($urandom_range(1, 3));
                    default: d = 8'h00;
                endcase
                exp_len = model_write(1'b0, d);
                bus_access(1'b0, 1'b0, d, w, rd, oe);
            end else if (op == 1) begin
                d = 8'($urandom_range(0, 255));
                exp_len = model_write(1'b1, d);
                bus_access(1'b1, 1'b0, d, w, rd, oe);
            end else if (op == 2) begin
                exp_rd  = m_ram[m_ac];
                m_ac    = (m_ac + (m_id ? 1 : DEPTH - 1)) % DEPTH;
                exp_len = CMD;
                bus_access(1'b1, 1'b1, 8'h00, w, rd, oe);
                checks++; if (rd !== exp_rd || oe !== 1'b1) begin errors++; $display("FAIL rnd_data_read[%0d]: got %h oe=%b want %h", k, rd, oe, exp_rd); end
            end else begin
                exp_rd  = {1'b0, 7'(m_ac)};
                exp_len = 0;
                bus_access(1'b0, 1'b1, 8'h00, w, rd, oe);
                checks++; if (rd !== exp_rd || oe !== 1'b1) begin errors++; $display("FAIL rnd_status[%0d]: got %h oe=%b want %h", k, rd, oe, exp_rd); end
            end
            measure_busy(n);
            checks++; if (n != exp_len) begin errors++; $display("FAIL rnd_busy[%0d]: op=%0d got %0d want %0d", k, op, n, exp_len); end
            checks++; if (ddram_addr !== 7'(m_ac) || disp_shift !== 7'(m_shift) || flags !== model_flags()) begin
                errors++; $display("FAIL rnd_state[%0d]: ac=%0d sh=%0d fl=%h want %0d %0d %h", k, ddram_addr, disp_shift, flags, m_ac, m_shift, model_flags());
            end
            a = $urandom_range(0, DEPTH - 1);
            read_ram(a, v);
            checks++; if (v !== m_ram[a]) begin errors++; $display("FAIL rnd_ram[%0d]: addr %0d got %h want %h", k, a, v, m_ram[a]); end
        end
    endtask

    initial begin
        bus.e = 1'b0; bus.rs = 1'b0; bus.rw = 1'b0; bus.lcd_data_in = 8'h00;
        disp_rd_addr = 7'd0;
        test_reset();
        test_init();
        test_data_write();
        test_clear();
        test_wrap();
        test_reset_mid_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
